stream_arb_2to1: RTL and testbench

- Two-source, 8-bit valid/ready stream arbiter.
- Each source has a one-entry holding buffer. The block picks one buffered byte per cycle, round-robin, into a registered output stage.
- Its out_src output drives the sel input of the downstream 8-bit 2:1 mux datapath. out_data carries the selected byte with its handshake.
- Sits directly upstream of the byte mux stage and serialises two producers onto one consumer.

---
 rtl/stream_arb_2to1_pkg.sv | 7 +
 rtl/stream_arb_2to1_byte_slot.sv | 24 ++
 rtl/stream_arb_2to1.sv | 80 ++++++++
 tb/tb_stream_arb_2to1.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_2to1_pkg.sv
// stream_arb_2to1_pkg: shared source ids and default widths for the 2:1 stream arbiter
package stream_arb_2to1_pkg;
   localparam logic SRC0 = 1'b0;
   localparam logic SRC1 = 1'b1;
   localparam int WIDTH_DEF = 8;
   localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/stream_arb_2to1_byte_slot.sv
// byte_slot: one-entry holding buffer with load/unload, full flag and sync clear
module byte_slot
   import stream_arb_2to1_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             unload,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic [WIDTH-1:0] dout
);
   // a load wins over an unload on the same edge so the slot refills without a bubble
   always_ff @(posedge clk)
      if (rst) begin
         full <= 1'b0;
         dout <= '0;
      end else begin
         full <= load ? 1'b1 : (unload ? 1'b0 : full);
         if (load) dout <= din;
      end
endmodule

// File: rtl/stream_arb_2to1.sv
// stream_arb_2to1: round-robin 2:1 valid/ready byte arbiter with registered output and per-source counters
module stream_arb_2to1
   import stream_arb_2to1_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in0_data,
   input  logic             in0_valid,
   output logic             in0_ready,
   input  logic [WIDTH-1:0] in1_data,
   input  logic             in1_valid,
   output logic             in1_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_src,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);
   logic             full0, full1, last, free, gnt_any, gnt, grant0, grant1;
   logic [WIDTH-1:0] data0, data1;

   // grant only into a free output slot; on a tie the source not served last wins
   always_comb begin
      free      = ~out_valid | out_ready;
      gnt_any   = free & (full0 | full1);
      gnt       = (full0 & full1) ? ~last : (full1 ? SRC1 : SRC0);
      grant0    = gnt_any & (gnt == SRC0);
      grant1    = gnt_any & (gnt == SRC1);
      in0_ready = ~rst & (~full0 | grant0);
      in1_ready = ~rst & (~full1 | grant1);
   end

   byte_slot #(.WIDTH(WIDTH)) u_slot0 (
      .clk    (clk),
      .rst    (rst),
      .load   (in0_valid & in0_ready),
      .unload (grant0),
      .din    (in0_data),
      .full   (full0),
      .dout   (data0)
   );

   byte_slot #(.WIDTH(WIDTH)) u_slot1 (
      .clk    (clk),
      .rst    (rst),
      .load   (in1_valid & in1_ready),
      .unload (grant1),
      .din    (in1_data),
      .full   (full1),
      .dout   (data1)
   );

   // output stage, priority pointer and delivered-byte counters; data/src hold when no new grant
   always_ff @(posedge clk)
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_src   <= SRC0;
         last      <= SRC1;
         cnt0      <= '0;
         cnt1      <= '0;
      end else begin
         if (out_valid && out_ready) begin
            if (out_src == SRC0) cnt0 <= cnt0 + 1'b1;
            else cnt1 <= cnt1 + 1'b1;
         end
         if (gnt_any) begin
            out_data  <= (gnt == SRC1) ? data1 : data0;
            out_src   <= gnt;
            out_valid <= 1'b1;
            last      <= gnt;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
endmodule

// File: tb/tb_stream_arb_2to1.sv
// tb_stream_arb_2to1: table-driven and sequence checks for the 2:1 stream arbiter
module tb_stream_arb_2to1;
   logic       clk, rst;
   logic [7:0] in0_data, in1_data, out_data, cnt0, cnt1;
   logic       in0_valid, in0_ready, in1_valid, in1_ready;
   logic       out_valid, out_ready, out_src;
   int         pass_cnt = 0;
   int         total_cnt = 0;

   typedef struct {
      logic       i0v;
      logic [7:0] i0d;
      logic       i1v;
      logic [7:0] i1d;
      logic       ordy;
      logic       ov;
      logic [7:0] od;
      logic       os;
      logic       r0;
      logic       r1;
      logic [7:0] c0;
      logic [7:0] c1;
   } vec_t;

   vec_t tbl[14];

   stream_arb_2to1 dut (
      .clk       (clk),
      .rst       (rst),
      .in0_data  (in0_data),
      .in0_valid (in0_valid),
      .in0_ready (in0_ready),
      .in1_data  (in1_data),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_src   (out_src),
      .cnt0      (cnt0),
      .cnt1      (cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic i0v, input logic [7:0] i0d, input logic i1v,
                               input logic [7:0] i1d, input logic ordy, input logic ov,
                               input logic [7:0] od, input logic os, input logic r0,
                               input logic r1, input logic [7:0] c0, input logic [7:0] c1);
      vec_t v;
      v.i0v = i0v; v.i0d = i0d; v.i1v = i1v; v.i1d = i1d; v.ordy = ordy;
      v.ov = ov; v.od = od; v.os = os; v.r0 = r0; v.r1 = r1; v.c0 = c0; v.c1 = c1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic stream(input logic src, input int n, input logic [7:0] first);
      int sent = 0;
      int rcvd = 0;
      int cyc = 0;
      out_ready = 1'b1;
      while (rcvd < n && cyc < n + 10) begin
         in0_valid = (src == 1'b0) && (sent < n);
         in1_valid = (src == 1'b1) && (sent < n);
         in0_data  = first + sent[7:0];
         in1_data  = first + sent[7:0];
         #1;
         if (out_valid && out_ready) begin
            chk("stream_beat", {out_src, out_data}, {src, 8'(first + rcvd[7:0])});
            rcvd++;
         end
         if (src ? (in1_valid && in1_ready) : (in0_valid && in0_ready)) sent++;
         tick();
         cyc++;
      end
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      chk("stream_cycles", 64'(cyc), 64'(n + 2));
      chk("stream_cnt", {cnt0, cnt1}, src ? {8'd0, 8'(n)} : {8'(n), 8'd0});
   endtask

   initial begin
      tbl[0]  = mk(1, 8'hAA, 1, 8'h55, 1, 0, 8'h00, 0, 1, 1, 0, 0);
      tbl[1]  = mk(1, 8'hAA, 1, 8'h55, 1, 0, 8'h00, 0, 1, 0, 0, 0);
      tbl[2]  = mk(1, 8'hAA, 1, 8'h55, 1, 1, 8'hAA, 0, 0, 1, 0, 0);
      tbl[3]  = mk(1, 8'hAA, 1, 8'h55, 1, 1, 8'h55, 1, 1, 0, 1, 0);
      tbl[4]  = mk(1, 8'hAA, 1, 8'h55, 1, 1, 8'hAA, 0, 0, 1, 1, 1);
      for (int i = 5; i < 10; i++) tbl[i] = mk(1, 8'hAA, 1, 8'h55, 0, 1, 8'h55, 1, 0, 0, 2, 1);
      tbl[10] = mk(0, 8'h00, 0, 8'h00, 1, 1, 8'h55, 1, 1, 0, 2, 1);
      tbl[11] = mk(0, 8'h00, 0, 8'h00, 1, 1, 8'hAA, 0, 1, 1, 2, 2);
      tbl[12] = mk(0, 8'h00, 0, 8'h00, 1, 1, 8'h55, 1, 1, 1, 3, 2);
      tbl[13] = mk(0, 8'h00, 0, 8'h00, 1, 0, 8'h55, 1, 1, 1, 3, 3);
      in0_data = 8'h00;
      in1_data = 8'h00;
      @(negedge clk);
      rst = 1'b1;
      in0_valid = 1'b1;
      in0_data = 8'hAA;
      in1_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("reset_state", {in0_ready, out_valid, cnt0, cnt1}, {1'b0, 1'b0, 16'h0});
         tick();
      end
      rst = 1'b0;
      #1;
      chk("first_accept", {in0_ready, out_valid}, 2'b10);
      tick();
      in0_valid = 1'b0;
      #1;
      chk("first_latency", {8'h0, out_valid}, 9'h0);
      tick();
      chk("first_out", {out_valid, out_src, out_data}, {1'b1, 1'b0, 8'hAA});
      do_reset();
      for (int i = 0; i < 14; i++) begin
         in0_valid = tbl[i].i0v;
         in0_data  = tbl[i].i0d;
         in1_valid = tbl[i].i1v;
         in1_data  = tbl[i].i1d;
         out_ready = tbl[i].ordy;
         #1;
         chk($sformatf("vec%0d", i),
             {out_valid, out_data, out_src, in0_ready, in1_ready, cnt0, cnt1},
             {tbl[i].ov, tbl[i].od, tbl[i].os, tbl[i].r0, tbl[i].r1, tbl[i].c0, tbl[i].c1});
         tick();
      end
      do_reset();
      stream(1'b0, 16, 8'h01);
      do_reset();
      stream(1'b1, 256, 8'h00);
      do_reset();
      in0_valid = 1'b1;
      in0_data  = 8'h11;
      in1_valid = 1'b1;
      in1_data  = 8'h22;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      #1;
      chk("pre_reset_full", {out_valid, in0_ready, in1_ready, out_data}, {3'b100, 8'h11});
      rst = 1'b1;
      #1;
      chk("reset_ready_low", {in0_ready, in1_ready}, 2'b00);
      tick();
      rst = 1'b0;
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("post_reset", {out_valid, in0_ready, in1_ready, cnt0, cnt1}, {3'b011, 16'h0});
      in1_valid = 1'b1;
      in1_data  = 8'h77;
      tick();
      in1_valid = 1'b0;
      tick();
      chk("post_reset_first", {out_valid, out_src, out_data}, {1'b1, 1'b1, 8'h77});
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
